dac_array_spi_ctrl: RTL

Parametrised controller for an array of MCP4922 dual 12-bit DACs sharing one SPI bus (SCK/SDI) with per-device chip selects and a common LDAC. Host logic writes individual channel values into a staging bank, then issues a commit. The block serialises the changed channels, or all channels, then pulses LDAC so every output moves simultaneously. It sits between the bias/tuning control logic and the DAC board pins.

---
 rtl/dac_array_spi_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dac_array_spi_ctrl.sv
// Staged-write SPI controller for a chain of MCP4922 DACs with shared SCK/SDI, per-device CS and common LDAC.
// Optional feature macro DAC_SKIP_CLEAN_EN: when defined only dirty channels are sent; otherwise every channel is sent.
module dac_array_spi_ctrl #(
    parameter int NUM_DACS = 12,
    parameter int CLK_DIV  = 25,
    parameter int LDAC_LOW = 4,
    parameter int CHW      = $clog2(2*NUM_DACS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [CHW-1:0]      wr_ch,
    input  logic [11:0]         wr_data,
    output logic                wr_err,
    input  logic                commit,
    input  logic                cfg_buf,
    input  logic                cfg_gain2x,
    output logic                spi_sck,
    output logic                spi_sdi,
    output logic [NUM_DACS-1:0] dac_cs_n,
    output logic                dac_ldac_n,
    output logic                busy,
    output logic                done,
    output logic [7:0]          words_sent,
    output logic [15:0]         commit_count
);
    localparam int NCH  = 2*NUM_DACS;
    localparam int DIVW = $clog2(CLK_DIV) + 1;
    localparam int LW   = $clog2(LDAC_LOW) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_LOAD, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_CS_GAP, S_LDAC, S_DONE
    } state_t;

    state_t              r_state;
    logic [DIVW-1:0]     r_div;
    logic [4:0]          r_ph;
    logic [15:0]         r_shift;
    logic [CHW-1:0]      r_ch;
    logic [NCH-1:0]      r_mask;
    logic [NCH-1:0]      r_dirty;
    logic [11:0]         r_stage  [NCH];
    logic [11:0]         r_active [NCH];
    logic                r_pending;
    logic [LW-1:0]       r_ldac_cnt;
    logic                r_wr_err;
    logic                r_sck;
    logic                r_sdi;
    logic [NUM_DACS-1:0] r_cs_n;
    logic                r_ldac_n;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_words;
    logic [15:0]         r_count;

    logic                w_tick;
    logic                w_wr_ok;
    logic                w_snap;
    logic                w_any;
    logic [CHW-1:0]      w_next_ch;
    logic [NUM_DACS-1:0] w_dev_sel;
    logic [NCH-1:0]      w_snap_mask;

    assign w_tick  = (r_div == DIVW'(CLK_DIV - 1));
    assign w_wr_ok = wr_valid && ({1'b0, wr_ch} < (CHW+1)'(NCH));
    assign w_snap  = (r_state == S_IDLE) && (commit || r_pending);

`ifdef DAC_SKIP_CLEAN_EN
    assign w_snap_mask = r_dirty;
`else
    // Dirty bits are still maintained, but every channel goes out on each commit.
    assign w_snap_mask = r_dirty | {NCH{1'b1}};
`endif

    // Lowest-index pending channel wins.
    always_comb begin
        w_any     = 1'b0;
        w_next_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_any     = 1'b1;
                w_next_ch = CHW'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DACS; gi++) begin : g_dev
            assign w_dev_sel[gi] = ((r_ch >> 1) == CHW'(gi));
        end
    endgenerate

    // Staging bank: writes land every cycle; a write coinciding with a snapshot stays dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) r_stage[i] <= '0;
            r_dirty  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_valid && !w_wr_ok;
            if (w_snap) r_dirty <= '0;
            if (w_wr_ok) begin
                r_stage[wr_ch] <= wr_data;
                r_dirty[wr_ch] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_ph       <= '0;
            r_shift    <= '0;
            r_ch       <= '0;
            r_mask     <= '0;
            for (int i = 0; i < NCH; i++) r_active[i] <= '0;
            r_pending  <= 1'b0;
            r_ldac_cnt <= '0;
            r_sck      <= 1'b0;
            r_sdi      <= 1'b0;
            r_cs_n     <= '1;
            r_ldac_n   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_words    <= '0;
            r_count    <= '0;
        end else begin
            r_done <= 1'b0;
            if (commit && r_state != S_IDLE) r_pending <= 1'b1;
            if (r_state inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_CS_GAP})
                r_div <= w_tick ? '0 : r_div + 1'b1;
            else
                r_div <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_snap) begin
                        r_pending <= 1'b0;
                        for (int i = 0; i < NCH; i++) r_active[i] <= r_stage[i];
                        r_mask    <= w_snap_mask;
                        r_words   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_any) begin
                        r_ch              <= w_next_ch;
                        r_mask[w_next_ch] <= 1'b0;
                        r_state           <= S_LOAD;
                    end else if (r_words == 8'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ldac_n   <= 1'b0;
                        r_ldac_cnt <= '0;
                        r_state    <= S_LDAC;
                    end
                end
                S_LOAD: begin
                    r_shift <= {r_ch[0], cfg_buf, ~cfg_gain2x, 1'b1, r_active[r_ch]};
                    r_words <= r_words + 8'd1;
                    r_cs_n  <= ~w_dev_sel;
                    r_state <= S_CS_SETUP;
                end
                S_CS_SETUP: begin
                    if (w_tick) begin
                        r_sdi   <= r_shift[15];
                        r_shift <= {r_shift[14:0], 1'b0};
                        r_ph    <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Even phases raise SCK; odd phases drop it and present the next bit.
                    if (w_tick) begin
                        r_ph <= r_ph + 5'd1;
                        if (!r_ph[0]) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_ph == 5'd31) begin
                                r_state <= S_CS_HOLD;
                            end else begin
                                r_sdi   <= r_shift[15];
                                r_shift <= {r_shift[14:0], 1'b0};
                            end
                        end
                    end
                end
                S_CS_HOLD: begin
                    if (w_tick) begin
                        r_cs_n  <= '1;
                        r_sdi   <= 1'b0;
                        r_state <= S_CS_GAP;
                    end
                end
                S_CS_GAP: begin
                    if (w_tick) r_state <= S_SCAN;
                end
                S_LDAC: begin
                    if (r_ldac_cnt == LW'(LDAC_LOW - 1)) begin
                        r_ldac_n <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_ldac_cnt <= r_ldac_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_count <= r_count + 16'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_err       = r_wr_err;
    assign spi_sck      = r_sck;
    assign spi_sdi      = r_sdi;
    assign dac_cs_n     = r_cs_n;
    assign dac_ldac_n   = r_ldac_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign words_sent   = r_words;
    assign commit_count = r_count;

endmodule
